// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared state, opcode and control-code definitions for mc_control
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_TRAP   = 4'd11
  } state_e;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// mem_wait_timer : counts memory wait cycles and flags when the limit is hit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout_on
      assign expired_o = (cnt_q == CW'(MEM_TIMEOUT));
    end else begin : g_timeout_off
      // A zero limit means wait forever; the counter value is never consulted.
      logic w_unused;
      assign w_unused  = ^cnt_q;
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// mc_control : multi-cycle RV32-subset sequencing FSM with memory handshake
// Optional: MC_CONTROL_PERF_EN adds cycle and retired-instruction counters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [6:0]  Op_i,
  input  logic        Zero_i,
  input  logic        mem_ready_i,
  output logic        MemReq_o,
  output logic        MemSel_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic [1:0]  ALUOp_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [1:0]  err_o,
  output logic [3:0]  state_o
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);

  state_e     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic       w_access;
  logic       w_waiting;
  logic       w_expired;

  assign w_access  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign w_waiting = w_access && !mem_ready_i;

  // Any cycle that is not a stalled access clears the counter, so every access starts at 0.
  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (!w_waiting),
    .en_i      (w_waiting && !w_expired),
    .expired_o (w_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    MemReq_o   = 1'b0;
    MemSel_o   = 1'b0;
    MemWrite_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = SRCB_RS2;
    ALUOp_o    = ALUOP_ADD;
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        MemReq_o  = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end else if (w_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcB_o = SRCB_IMM;
        case (Op_i)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_SD: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            err_d   = ERR_ILLEGAL;
            state_d = S_TRAP;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_FUNCT;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = S_WB_ALU;
      end
      S_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (Op_i == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemReq_o = 1'b1;
        MemSel_o = 1'b1;
        if (mem_ready_i) begin
          state_d = S_WB_MEM;
        end else if (w_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_TRAP;
        end
      end
      S_MEM_WR: begin
        MemReq_o   = 1'b1;
        MemSel_o   = 1'b1;
        MemWrite_o = 1'b1;
        if (mem_ready_i) begin
          state_d = S_FETCH;
        end else if (w_expired) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_TRAP;
        end
      end
      S_WB_ALU: begin
        RegWrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_SUB;
        PCSrc_o   = 1'b1;
        PCWrite_o = Zero_i;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err_o   = err_q;
  assign state_o = state_q;

`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_cnt_q, instret_q;
  logic        w_retire;

  assign w_retire = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WR) && mem_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      if ((state_q != S_IDLE) && (state_q != S_TRAP))
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (w_retire)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instret_o   = instret_q;
`endif

endmodule

`default_nettype wire
